// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC operation codes.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4
  } op_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. Pushing when full overwrites the oldest
// entry; popping when empty is ignored. Both set a sticky error flag.
module pc_ras #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             error
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             error_q, error_d;
  logic             wr_en;
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(RAS_DEPTH));
  assign error = error_q;
  // ptr_q is the next write slot; once full it also addresses the oldest entry.
  assign top   = mem_q[ptr_q - PW'(1)];

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    error_d = error_q;
    wr_en   = 1'b0;
    if (push) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PW'(1);
      if (full) error_d = 1'b1;
      else      count_d = count_q + CW'(1);
    end else if (pop) begin
      if (empty) begin
        error_d = 1'b1;
      end else begin
        ptr_d   = ptr_q - PW'(1);
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC selection (inc/branch/jump/call/ret) backed
// by a return-address stack.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned STEP         = 2,
  parameter int unsigned RAS_DEPTH    = 4,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Stall,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] Offset,
  input  logic [WIDTH-1:0] Target,
  output logic [WIDTH-1:0] DataOut,
  output logic [WIDTH-1:0] PCPlus,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasError
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push, ras_pop;

  assign DataOut = pc_q;
  assign PCPlus  = pc_q + WIDTH'(STEP);

  always_comb begin
    pc_d     = PCPlus;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (Stall) begin
      pc_d = pc_q;
    end else begin
      case (Op)
        OP_BRANCH: pc_d = pc_q + Offset;
        OP_JUMP:   pc_d = Target;
        OP_CALL: begin
          ras_push = 1'b1;
          pc_d     = Target;
        end
        OP_RET: begin
          ras_pop = 1'b1;
          pc_d    = RasEmpty ? PCPlus : ras_top;
        end
        default:   pc_d = PCPlus;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) pc_q <= WIDTH'(RESET_VECTOR);
    else       pc_q <= pc_d;
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (Reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (PCPlus),
    .top       (ras_top),
    .empty     (RasEmpty),
    .full      (RasFull),
    .error     (RasError)
  );

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 16: PC and address width in bits.
REQ-002 Parameter STEP, default 2: sequential increment in address units.
REQ-003 Parameter RAS_DEPTH, default 4: return-address stack entries, power of two, at least 2.
REQ-004 Parameter RESET_VECTOR, default 0: PC value after reset.
REQ-005 CLK  in  1: single clock; all state updates on the rising edge.
REQ-006 Reset  in  1: synchronous, active-high reset.
REQ-007 Stall  in  1: when 1, hold all state.
REQ-008 Op  in  3: next-PC operation (encoding in REQ-014).
REQ-009 Offset  in  WIDTH: two's-complement branch displacement.
REQ-010 Target  in  WIDTH: absolute jump/call address.
REQ-011 DataOut  out  WIDTH: current PC, registered.
REQ-012 PCPlus  out  WIDTH: DataOut+STEP, combinational from DataOut.
REQ-013 RasEmpty, RasFull, RasError  out  1 each: stack empty; stack full; sticky overflow/underflow flag.

Function
REQ-014 Op encoding: 0 INC, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET; codes 5-7 SHALL behave as INC.
REQ-015 INC: next PC = PC+STEP.
REQ-016 BRANCH: next PC = PC+Offset.
REQ-017 JUMP: next PC = Target.
REQ-018 CALL: push PC+STEP, then next PC = Target.
REQ-019 RET with stack non-empty: next PC = top entry; pop.
REQ-020 Latency: the new PC SHALL appear on DataOut one cycle after the Op edge; no bubbles.
REQ-021 Arithmetic: all sums modulo 2^WIDTH; wrap-around is silent and is not an error.
REQ-022 Stall=1 SHALL hold PC, stack contents, pointers and flags regardless of Op.
REQ-023 Stack occupancy count range is 0..RAS_DEPTH:
- RasEmpty = (count==0)
- RasFull = (count==RAS_DEPTH)
REQ-024 CALL when full: overwrite the oldest entry (circular); count stays RAS_DEPTH; set RasError.
REQ-025 RET when empty: next PC = PC+STEP; count stays 0; set RasError.
REQ-026 RasError is sticky and is cleared only by Reset.
REQ-027 Stall is the only hold condition; no other simultaneous-event priority exists, because Op selects exactly one action per cycle.

Reset
REQ-028 On Reset=1 at a rising edge:
- DataOut = RESET_VECTOR
- PCPlus = RESET_VECTOR+STEP
- count = 0, RasEmpty = 1, RasFull = 0, RasError = 0
REQ-029 Reset SHALL override Stall and any Op, including mid-call sequences; stack entry contents need not be cleared.
REQ-030 Before the first reset, output values are unspecified.

Structure
REQ-031 A shared package SHALL hold the Op encoding constants (OP_INC, OP_BRANCH, OP_JUMP, OP_CALL, OP_RET).
REQ-032 The return-address stack SHALL be a sub-module pc_ras with push, pop, top, empty, full and error ports, parametrised by WIDTH and RAS_DEPTH.
REQ-033 The PC register and next-PC mux SHALL reside in pc_unit.

Verification
REQ-034 Reset, then 3 INC cycles -> DataOut 0, 2, 4, 6; PCPlus 8 on the last cycle.
REQ-035 PC=0x0010, BRANCH Offset=0xFFF0 -> DataOut=0x0000; PC=0xFFFE, INC -> 0x0000 with RasError=0.
REQ-036 PC=0x0004, CALL Target=0x0100, then RET -> DataOut 0x0100, then 0x0006; RasEmpty returns to 1.
REQ-037 Five nested CALLs from PCs 0,0x10,0x20,0x30,0x40, then four RETs -> returns 0x42, 0x32, 0x22, 0x12; RasError=1 from the fifth CALL onward.
REQ-038 Stall=1 for 3 cycles with Op=JUMP, Target=0x0200 -> DataOut unchanged; then Stall=0 -> 0x0200 next cycle.
REQ-039 RET on empty from PC=0x0008 -> DataOut=0x000A, RasError=1; Reset with Stall=1 -> DataOut=RESET_VECTOR, RasError=0.
